heartbeat_watchdog: RTL

HEARTBEAT_WATCHDOG -- requirements
Module: heartbeat_watchdog

---
 rtl/heartbeat_watchdog.sv | 105 ++++++++++
 1 files changed

// File: rtl/heartbeat_watchdog.sv
// Watchdog for a microcontroller heartbeat pin, with a 1-cycle error pulse per fault; pin-to-edge latency 3 cycles.
// No backpressure; optional early-heartbeat window check when WATCHDOG_WINDOW_EN is defined.
module heartbeat_watchdog #(
    parameter logic [23:0] TIMEOUT_CYCLES = 24'd5000000,
    parameter logic [23:0] GRACE_CYCLES   = 24'd1000000,
    parameter logic [23:0] RESP_CYCLES    = 24'd1000,
    parameter logic [23:0] MIN_CYCLES     = 24'd1000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       heartbeat,
    input  logic       resetuC,
    output logic       error,
    output logic       alive,
    output logic [7:0] fault_count,
    output logic [2:0] state
);

`ifdef WATCHDOG_WINDOW_EN
    localparam bit WINDOW_EN = 1'b1;
`else
    localparam bit WINDOW_EN = 1'b0;
`endif

    typedef enum logic [2:0] {
        S_GRACE    = 3'd0,
        S_ARMED    = 3'd1,
        S_FAULT    = 3'd2,
        S_WAIT_ACK = 3'd3,
        S_HOLD     = 3'd4
    } state_t;

    state_t      state_q, state_d;
    logic [23:0] cnt_q, cnt_d;
    logic        hb_s1_q, hb_s2_q, hb_prev_q;
    logic        rst_s1_q, rst_s2_q;
    logic        error_q, alive_q;
    logic [7:0]  fault_cnt_q;
    logic        hb_edge;

    assign hb_edge = hb_s2_q ^ hb_prev_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + 24'd1;
        if (!rst_s2_q) begin
            state_d = S_HOLD;
        end else begin
            case (state_q)
                S_GRACE: begin
                    if (cnt_q == GRACE_CYCLES - 24'd1) state_d = S_ARMED;
                end
                S_ARMED: begin
                    // A heartbeat edge beats a simultaneous timeout.
                    if (hb_edge) begin
                        if (WINDOW_EN && (cnt_q < MIN_CYCLES - 24'd1)) state_d = S_FAULT;
                        else                                           cnt_d   = '0;
                    end else if (cnt_q == TIMEOUT_CYCLES - 24'd1) begin
                        state_d = S_FAULT;
                    end
                end
                S_FAULT: state_d = S_WAIT_ACK;
                S_WAIT_ACK: begin
                    if (cnt_q == RESP_CYCLES - 24'd1) state_d = S_FAULT;
                end
                S_HOLD:  state_d = S_GRACE;
                default: state_d = S_GRACE;
            endcase
        end
        if ((state_d != state_q) || (state_d == S_HOLD)) cnt_d = '0;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hb_s1_q     <= 1'b0;
            hb_s2_q     <= 1'b0;
            hb_prev_q   <= 1'b0;
            rst_s1_q    <= 1'b1;
            rst_s2_q    <= 1'b1;
            state_q     <= S_GRACE;
            cnt_q       <= '0;
            error_q     <= 1'b0;
            alive_q     <= 1'b0;
            fault_cnt_q <= '0;
        end else begin
            hb_s1_q   <= heartbeat;
            hb_s2_q   <= hb_s1_q;
            hb_prev_q <= hb_s2_q;
            rst_s1_q  <= resetuC;
            rst_s2_q  <= rst_s1_q;
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            error_q   <= (state_d == S_FAULT);
            alive_q   <= (state_d == S_ARMED);
            if ((state_q == S_FAULT) && (fault_cnt_q != 8'hFF))
                fault_cnt_q <= fault_cnt_q + 8'd1;
        end
    end

    assign error       = error_q;
    assign alive       = alive_q;
    assign fault_count = fault_cnt_q;
    assign state       = state_q;

endmodule
